// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair: state encodings,
// default frame geometry and the idle line level.
package serdes_pkg;

    localparam int DEFAULT_DATA_LENGTH = 16;
    localparam int DEFAULT_WORD_SIZE   = 8;

    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_LEAD   = 3'd2;
    localparam logic [2:0] ST_SHIFT  = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;

    function automatic int words_per_frame(input int data_length, input int word_size);
        return data_length / word_size;
    endfunction

endpackage

// File: rtl/serializer_with_counter_if.sv
// Parallel word handshake between a word source (master) and the serializer (slave).
interface serializer_with_counter_if
    import serdes_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);
    logic [WORD_SIZE-1:0] word_in;
    logic                 word_valid;
    logic                 word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/frame_shift_register.sv
// Frame register: word-indexed parallel load, right shift filling with the idle level,
// and bit 0 exposed as the serial tap.
module frame_shift_register
    import serdes_pkg::*;
#(
    parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH,
    parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int IDX_W       = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [IDX_W-1:0]     load_idx,
    input  logic [WORD_SIZE-1:0] load_word,
    input  logic                 shift_en,
    output logic                 tap
);
    logic [DATA_LENGTH-1:0] frame_q, frame_d;

    always_comb begin
        frame_d = frame_q;
        if (load_en) begin
            frame_d[int'(load_idx) * WORD_SIZE +: WORD_SIZE] = load_word;
        end else if (shift_en) begin
            frame_d = {IDLE_LEVEL, frame_q[DATA_LENGTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign tap = frame_q[0];
endmodule

// File: rtl/serializer_with_counter.sv
// Bit-serial transmitter: gathers a frame of parallel words, then sends start, idle lead
// and LSB-first data. Define SERIALIZER_PARITY_EN to append an even-parity bit.
module serializer_with_counter
    import serdes_pkg::*;
#(
    parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH,
    parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int LEAD_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    serializer_with_counter_if.slave word_bus,
    output logic start,
    output logic serial_out,
    output logic busy,
    output logic RCO
);
    localparam int WORDS      = words_per_frame(DATA_LENGTH, WORD_SIZE);
    localparam int WORD_CNT_W = $clog2(WORDS + 1);
    localparam int BIT_CNT_W  = $clog2(DATA_LENGTH + 1);
    localparam int LEAD_CNT_W = (LEAD_CYCLES > 0) ? $clog2(LEAD_CYCLES + 1) : 1;

    if (DATA_LENGTH % WORD_SIZE != 0) begin : g_bad_length
        $error("DATA_LENGTH must be an integer multiple of WORD_SIZE");
    end

    logic [2:0]            state_q, state_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [LEAD_CNT_W-1:0] lead_cnt_q, lead_cnt_d;
    logic                  accept;
    logic                  last_bit;
    logic                  tap;
`ifdef SERIALIZER_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign accept   = word_bus.word_valid && (state_q == ST_IDLE);
    assign last_bit = (bit_cnt_q == BIT_CNT_W'(DATA_LENGTH - 1));

    frame_shift_register #(
        .DATA_LENGTH(DATA_LENGTH),
        .WORD_SIZE  (WORD_SIZE),
        .IDX_W      (WORD_CNT_W)
    ) u_frame (
        .clock    (clock),
        .reset    (reset),
        .load_en  (accept),
        .load_idx (word_cnt_q),
        .load_word(word_bus.word_in),
        .shift_en (state_q == ST_SHIFT),
        .tap      (tap)
    );

    // Parity accumulates over the bits as they leave, so the shift-in fill never disturbs it.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        lead_cnt_d = lead_cnt_q;
`ifdef SERIALIZER_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (word_cnt_q == WORD_CNT_W'(WORDS - 1)) begin
                        word_cnt_d = '0;
                        state_d    = ST_START;
                    end else begin
                        word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
                    end
                end
            end
            ST_START: begin
                bit_cnt_d  = '0;
                lead_cnt_d = LEAD_CNT_W'(LEAD_CYCLES - 1);
`ifdef SERIALIZER_PARITY_EN
                parity_d   = 1'b0;
`endif
                state_d    = (LEAD_CYCLES == 0) ? ST_SHIFT : ST_LEAD;
            end
            ST_LEAD: begin
                if (lead_cnt_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    lead_cnt_d = lead_cnt_q - LEAD_CNT_W'(1);
                end
            end
            ST_SHIFT: begin
`ifdef SERIALIZER_PARITY_EN
                parity_d = parity_q ^ tap;
`endif
                if (last_bit) begin
                    bit_cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
                    state_d   = ST_PARITY;
`else
                    state_d   = ST_IDLE;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
`ifdef SERIALIZER_PARITY_EN
            ST_PARITY: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            lead_cnt_q <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            lead_cnt_q <= lead_cnt_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign word_bus.word_ready = (state_q == ST_IDLE);
    assign start               = (state_q == ST_START);
    assign busy                = (state_q != ST_IDLE);

    always_comb begin
        serial_out = IDLE_LEVEL;
        if (state_q == ST_SHIFT) begin
            serial_out = tap;
        end
`ifdef SERIALIZER_PARITY_EN
        if (state_q == ST_PARITY) begin
            serial_out = parity_q;
        end
        RCO = (state_q == ST_PARITY);
`else
        RCO = (state_q == ST_SHIFT) && last_bit;
`endif
    end
endmodule

// File: tb/tb_serializer_with_counter.sv
// Directed bench for serializer_with_counter: a LEAD_CYCLES=2 instance and a LEAD_CYCLES=0 instance,
// plus a small receiver model on the main instance's serial line.
module tb_serializer_with_counter;
    import serdes_pkg::*;

    localparam int DL   = 16;
    localparam int LEAD = 2;
`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
    localparam logic [15:0] EXP_MASK = 16'h0000;
`else
    localparam int PAR = 0;
    localparam logic [15:0] EXP_MASK = 16'h8000;
`endif
    localparam int RX_BITS = DL + PAR;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    serializer_with_counter_if #(.WORD_SIZE(8)) bus ();
    serializer_with_counter_if #(.WORD_SIZE(8)) bus0 ();
    logic start, serial_out, busy, rco;
    logic start0, serial0, busy0, rco0;

    serializer_with_counter #(.DATA_LENGTH(DL), .WORD_SIZE(8), .LEAD_CYCLES(LEAD)) dut (
        .clock(clock), .reset(reset), .word_bus(bus),
        .start(start), .serial_out(serial_out), .busy(busy), .RCO(rco));

    serializer_with_counter #(.DATA_LENGTH(DL), .WORD_SIZE(8), .LEAD_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .word_bus(bus0),
        .start(start0), .serial_out(serial0), .busy(busy0), .RCO(rco0));

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Receiver model: waits for start, skips the lead, then shifts in LSB-first bits.
    int rx_state = 0;
    int rx_cnt = 0;
    int rx_frames = 0;
    int rx_done_cyc = -1;
    int rco_cyc = -1;
    logic [DL-1:0] rx_shift = '0;
    logic [DL-1:0] rx_frame = '0;
    logic rx_par = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            rx_state <= 0;
            rx_cnt   <= 0;
        end else begin
            if (rco === 1'b1) rco_cyc <= cyc;
            case (rx_state)
                0: if (start === 1'b1) begin
                    rx_cnt   <= 0;
                    rx_state <= (LEAD == 0) ? 2 : 1;
                end
                1: if (rx_cnt == LEAD - 1) begin
                    rx_cnt   <= 0;
                    rx_state <= 2;
                end else begin
                    rx_cnt <= rx_cnt + 1;
                end
                default: begin
                    if (rx_cnt < DL) rx_shift <= {serial_out, rx_shift[DL-1:1]};
                    else rx_par <= serial_out;
                    if (rx_cnt == RX_BITS - 1) begin
                        rx_state    <= 0;
                        rx_done_cyc <= cyc;
                        rx_frames   <= rx_frames + 1;
                        rx_frame    <= (rx_cnt < DL) ? {serial_out, rx_shift[DL-1:1]} : rx_shift;
                    end else begin
                        rx_cnt <= rx_cnt + 1;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_two(input logic [7:0] w0, input logic [7:0] w1);
        bus.word_valid = 1'b1;
        bus.word_in    = w0;
        tick();
        bus.word_in    = w1;
        tick();
        bus.word_valid = 1'b0;
        bus.word_in    = 8'h00;
    endtask

    // Called in the START cycle; returns in the last busy cycle of the frame.
    task automatic collect_frame(input logic junk, output logic [15:0] bits, output logic [15:0] rco_mask,
                                 output logic lead_high, output logic ready_low,
                                 output logic par_bit, output logic par_rco);
        lead_high = 1'b1;
        ready_low = (bus.word_ready === 1'b0);
        bits      = '0;
        rco_mask  = '0;
        par_bit   = 1'b0;
        par_rco   = 1'b0;
        for (int c = 0; c < LEAD; c++) begin
            if (junk) begin bus.word_in = 8'hFF; bus.word_valid = ~bus.word_valid; end
            tick();
            if (serial_out !== 1'b1 || rco !== 1'b0 || busy !== 1'b1) lead_high = 1'b0;
            if (bus.word_ready !== 1'b0) ready_low = 1'b0;
        end
        for (int i = 0; i < DL; i++) begin
            if (junk) begin bus.word_in = 8'hFF; bus.word_valid = ~bus.word_valid; end
            tick();
            bits[i]     = serial_out;
            rco_mask[i] = rco;
            if (bus.word_ready !== 1'b0) ready_low = 1'b0;
        end
`ifdef SERIALIZER_PARITY_EN
        if (junk) begin bus.word_in = 8'hFF; bus.word_valid = ~bus.word_valid; end
        tick();
        par_bit = serial_out;
        par_rco = rco;
        if (bus.word_ready !== 1'b0) ready_low = 1'b0;
`endif
        bus.word_valid = 1'b0;
        bus.word_in    = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.word_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", bus.word_ready); else passes++;
        checks++; if (start !== 1'b0) $display("[TB] FAIL reset_start: got %b expected 0", start); else passes++;
        checks++; if (serial_out !== 1'b1) $display("[TB] FAIL reset_serial: got %b expected 1", serial_out); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (rco !== 1'b0) $display("[TB] FAIL reset_rco: got %b expected 0", rco); else passes++;
        reset = 1'b0;
        tick();
        checks++; if (bus0.word_ready !== 1'b1 || serial0 !== 1'b1) $display("[TB] FAIL reset_dut0: got ready=%b serial=%b expected 1 1", bus0.word_ready, serial0); else passes++;
    endtask

    task automatic test_basic_frame();
        logic [15:0] bits, mask;
        logic lead_ok, ready_low, pb, pr;
        send_two(8'h51, 8'hB1);
        checks++; if (start !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL basic_start: got start=%b busy=%b expected 1 1", start, busy); else passes++;
        checks++; if (bus.word_ready !== 1'b0) $display("[TB] FAIL basic_ready_start: got %b expected 0", bus.word_ready); else passes++;
        collect_frame(1'b0, bits, mask, lead_ok, ready_low, pb, pr);
        checks++; if (lead_ok !== 1'b1) $display("[TB] FAIL basic_lead: got %b expected 1", lead_ok); else passes++;
        checks++; if (bits !== 16'hB151) $display("[TB] FAIL basic_bits: got %h expected b151", bits); else passes++;
        checks++; if (mask !== EXP_MASK) $display("[TB] FAIL basic_rco: got %h expected %h", mask, EXP_MASK); else passes++;
`ifdef SERIALIZER_PARITY_EN
        checks++; if (pb !== 1'b1 || pr !== 1'b1) $display("[TB] FAIL basic_parity: got bit=%b rco=%b expected 1 1", pb, pr); else passes++;
`endif
        tick();
        checks++; if (bus.word_ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL basic_return: got ready=%b busy=%b expected 1 0", bus.word_ready, busy); else passes++;
    endtask

    task automatic test_loopback();
        int base;
        bit done;
        base = rx_frames;
        done = 1'b0;
        send_two(8'hA5, 8'h3C);
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (rx_frames == base + 1) done = 1'b1;
        end
        checks++; if (!done) $display("[TB] FAIL loop_timeout: got %0d frames expected %0d", rx_frames - base, 1); else passes++;
        checks++; if (rx_frame[7:0] !== 8'hA5) $display("[TB] FAIL loop_word0: got %h expected a5", rx_frame[7:0]); else passes++;
        checks++; if (rx_frame[15:8] !== 8'h3C) $display("[TB] FAIL loop_word1: got %h expected 3c", rx_frame[15:8]); else passes++;
        checks++; if (rco_cyc !== rx_done_cyc) $display("[TB] FAIL loop_rco_align: got rco cycle %0d expected %0d", rco_cyc, rx_done_cyc); else passes++;
`ifdef SERIALIZER_PARITY_EN
        checks++; if (rx_par !== 1'b0) $display("[TB] FAIL loop_parity: got %b expected 0", rx_par); else passes++;
`endif
        tick();
        tick();
    endtask

    task automatic test_ignore_junk();
        logic [15:0] bits, mask;
        logic lead_ok, ready_low, pb, pr;
        send_two(8'h12, 8'h34);
        collect_frame(1'b1, bits, mask, lead_ok, ready_low, pb, pr);
        checks++; if (ready_low !== 1'b1) $display("[TB] FAIL junk_ready: got %b expected 1", ready_low); else passes++;
        checks++; if (bits !== 16'h3412) $display("[TB] FAIL junk_bits: got %h expected 3412", bits); else passes++;
        tick();
        bus.word_valid = 1'b1;
        bus.word_in    = 8'h56;
        tick();
        bus.word_valid = 1'b0;
        tick();
        checks++; if (start !== 1'b0 || bus.word_ready !== 1'b1) $display("[TB] FAIL junk_count: got start=%b ready=%b expected 0 1", start, bus.word_ready); else passes++;
        bus.word_valid = 1'b1;
        bus.word_in    = 8'h78;
        tick();
        bus.word_valid = 1'b0;
        checks++; if (start !== 1'b1) $display("[TB] FAIL junk_second_start: got %b expected 1", start); else passes++;
        collect_frame(1'b0, bits, mask, lead_ok, ready_low, pb, pr);
        checks++; if (bits !== 16'h7856) $display("[TB] FAIL junk_next_frame: got %h expected 7856", bits); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [4];
        logic ser [0:127];
        logic [15:0] f1, f2;
        int s_first, s_second, idx, rco_hits;
        logic take;
        words = '{8'h01, 8'h02, 8'h03, 8'h04};
        s_first = -1; s_second = -1; idx = 0; rco_hits = 0;
        bus.word_valid = 1'b1;
        bus.word_in    = words[0];
        for (int c = 0; c < 120; c++) begin
            take = bus.word_valid && bus.word_ready;
            tick();
            if (take) begin
                idx++;
                if (idx == 4) begin bus.word_valid = 1'b0; bus.word_in = 8'h00; end
                else bus.word_in = words[idx];
            end
            ser[c] = serial_out;
            if (rco === 1'b1) rco_hits++;
            if (start === 1'b1) begin
                if (s_first < 0) s_first = c;
                else if (s_second < 0) s_second = c;
            end
        end
        checks++; if (s_first < 0 || s_second < 0) $display("[TB] FAIL b2b_starts: got first=%0d second=%0d expected both found", s_first, s_second); else passes++;
        checks++; if (s_second - s_first !== 2 + LEAD + DL + 1 + PAR) $display("[TB] FAIL b2b_spacing: got %0d expected %0d", s_second - s_first, 2 + LEAD + DL + 1 + PAR); else passes++;
        if (s_first < 0) s_first = 0;
        if (s_second < 0 || s_second > 100) s_second = 0;
        for (int i = 0; i < DL; i++) begin
            f1[i] = ser[s_first + 1 + LEAD + i];
            f2[i] = ser[s_second + 1 + LEAD + i];
        end
        checks++; if (f1 !== 16'h0201) $display("[TB] FAIL b2b_frame1: got %h expected 0201", f1); else passes++;
        checks++; if (f2 !== 16'h0403) $display("[TB] FAIL b2b_frame2: got %h expected 0403", f2); else passes++;
        checks++; if (rco_hits !== 2) $display("[TB] FAIL b2b_rco_count: got %0d expected 2", rco_hits); else passes++;
    endtask

    task automatic test_mid_reset();
        logic [15:0] bits, mask;
        logic lead_ok, ready_low, pb, pr;
        send_two(8'hC3, 8'h5A);
        for (int c = 0; c < LEAD + 5; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (serial_out !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL midrst_line: got serial=%b busy=%b expected 1 0", serial_out, busy); else passes++;
        checks++; if (rco !== 1'b0 || bus.word_ready !== 1'b1) $display("[TB] FAIL midrst_status: got rco=%b ready=%b expected 0 1", rco, bus.word_ready); else passes++;
        bus.word_valid = 1'b1;
        bus.word_in    = 8'h11;
        tick();
        bus.word_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_two(8'h81, 8'h7E);
        checks++; if (start !== 1'b1) $display("[TB] FAIL midrst_start: got %b expected 1", start); else passes++;
        collect_frame(1'b0, bits, mask, lead_ok, ready_low, pb, pr);
        checks++; if (bits !== 16'h7E81) $display("[TB] FAIL midrst_frame: got %h expected 7e81", bits); else passes++;
        checks++; if (mask !== EXP_MASK) $display("[TB] FAIL midrst_rco: got %h expected %h", mask, EXP_MASK); else passes++;
        tick();
    endtask

    task automatic test_lead0_parity();
        logic [15:0] bits, mask;
        bus0.word_valid = 1'b1;
        bus0.word_in    = 8'h01;
        tick();
        bus0.word_in    = 8'h00;
        tick();
        bus0.word_valid = 1'b0;
        checks++; if (start0 !== 1'b1) $display("[TB] FAIL lead0_start: got %b expected 1", start0); else passes++;
        tick();
        bits[0] = serial0;
        mask[0] = rco0;
        checks++; if (serial0 !== 1'b1 || start0 !== 1'b0 || busy0 !== 1'b1) $display("[TB] FAIL lead0_bit0: got serial=%b start=%b busy=%b expected 1 0 1", serial0, start0, busy0); else passes++;
        for (int i = 1; i < DL; i++) begin
            tick();
            bits[i] = serial0;
            mask[i] = rco0;
        end
        checks++; if (bits !== 16'h0001) $display("[TB] FAIL lead0_bits: got %h expected 0001", bits); else passes++;
        checks++; if (mask !== EXP_MASK) $display("[TB] FAIL lead0_rco: got %h expected %h", mask, EXP_MASK); else passes++;
`ifdef SERIALIZER_PARITY_EN
        tick();
        checks++; if (serial0 !== 1'b1 || rco0 !== 1'b1 || busy0 !== 1'b1) $display("[TB] FAIL lead0_parity: got serial=%b rco=%b busy=%b expected 1 1 1", serial0, rco0, busy0); else passes++;
`endif
        tick();
        checks++; if (bus0.word_ready !== 1'b1 || busy0 !== 1'b0) $display("[TB] FAIL lead0_return: got ready=%b busy=%b expected 1 0", bus0.word_ready, busy0); else passes++;
    endtask

    initial begin
        reset           = 1'b1;
        bus.word_valid  = 1'b0;
        bus.word_in     = 8'h00;
        bus0.word_valid = 1'b0;
        bus0.word_in    = 8'h00;
        test_reset();
        test_basic_frame();
        test_loopback();
        test_ignore_junk();
        test_back_to_back();
        test_mid_reset();
        test_lead0_parity();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
